// File: rtl/tmr_register_file.sv
// Triplicated register file with majority-voted reads, a background scrubber
// that repairs disagreeing copies, and a single-bit fault-injection port.
module tmr_register_file #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG),
  parameter int unsigned CNTW = 8
) (
  input  logic                      clk,
  input  logic                      rst_in,
  input  logic                      WE3,
  input  logic [AW-1:0]             A1,
  input  logic [AW-1:0]             A2,
  input  logic [AW-1:0]             A3,
  input  logic [XLEN-1:0]           WD3,
  output logic [XLEN-1:0]           RD1,
  output logic [XLEN-1:0]           RD2,
  output logic                      rd_mismatch,
  input  logic                      inject_error,
  input  logic [1:0]                inj_copy,
  input  logic [AW-1:0]             inj_addr,
  input  logic [$clog2(XLEN)-1:0]   inj_bit,
  input  logic                      scrub_en,
  output logic                      scrub_busy,
  output logic                      scrub_pass,
  output logic [CNTW-1:0]           corr_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [XLEN-1:0] mem   [3][NREG];
  logic [XLEN-1:0] mem_d [3][NREG];

  logic [1:0]      state, state_d;
  logic [AW-1:0]   ptr, ptr_d;
  logic [AW-1:0]   fix_addr, fix_addr_d;
  logic [CNTW-1:0] corr_d;
  logic            pass_d;
  logic            fix_wr;

  logic            func_wr;
  logic            inj_ok;
  logic            ptr_bad;
  logic            ptr_wrap;
  logic [AW-1:0]   ptr_next;
  logic [XLEN-1:0] fix_val;

  function automatic logic [XLEN-1:0] vote(input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b,
                                           input logic [XLEN-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic differ(input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b,
                                  input logic [XLEN-1:0] c);
    return (a != b) || (b != c);
  endfunction

  assign func_wr  = WE3 && (A3 != '0);
  assign inj_ok   = inject_error && (inj_addr != '0) && (inj_copy != 2'd3);
  assign ptr_bad  = differ(mem[0][ptr], mem[1][ptr], mem[2][ptr]);
  assign ptr_wrap = (ptr == AW'(NREG - 1));
  assign ptr_next = ptr_wrap ? AW'(1) : ptr + AW'(1);
  assign fix_val  = vote(mem[0][fix_addr], mem[1][fix_addr], mem[2][fix_addr]);
  assign scrub_busy = (state != S_IDLE);

  // Zero-latency voted reads; register 0 is hard-wired to zero.
  always_comb begin
    RD1         = '0;
    RD2         = '0;
    rd_mismatch = 1'b0;
    if (A1 != '0) begin
      RD1 = vote(mem[0][A1], mem[1][A1], mem[2][A1]);
      if (differ(mem[0][A1], mem[1][A1], mem[2][A1])) rd_mismatch = 1'b1;
    end
    if (A2 != '0) begin
      RD2 = vote(mem[0][A2], mem[1][A2], mem[2][A2]);
      if (differ(mem[0][A2], mem[1][A2], mem[2][A2])) rd_mismatch = 1'b1;
    end
  end

  // Scrubber next-state: a fix yields to an unrelated functional write.
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    fix_addr_d = fix_addr;
    corr_d     = corr_count;
    pass_d     = 1'b0;
    fix_wr     = 1'b0;
    case (state)
      S_IDLE: begin
        if (scrub_en) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (!scrub_en) begin
          state_d = S_IDLE;
        end else if (ptr_bad) begin
          fix_addr_d = ptr;
          state_d    = S_FIX;
        end else begin
          ptr_d  = ptr_next;
          pass_d = ptr_wrap;
        end
      end
      S_FIX: begin
        if (!(func_wr && (A3 != fix_addr))) begin
          fix_wr = 1'b1;
          if (corr_count != '1) corr_d = corr_count + CNTW'(1);
          ptr_d   = ptr_next;
          pass_d  = ptr_wrap;
          state_d = scrub_en ? S_SCAN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scrubber state, pointer and status registers.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state      <= S_IDLE;
      ptr        <= AW'(1);
      fix_addr   <= '0;
      corr_count <= '0;
      scrub_pass <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      fix_addr   <= fix_addr_d;
      corr_count <= corr_d;
      scrub_pass <= pass_d;
    end
  end

  // Next array contents: scrub fix, then functional write, then injection on top.
  always_comb begin
    mem_d = mem;
    for (int c = 0; c < 3; c++) begin
      if (fix_wr)  mem_d[c][fix_addr] = fix_val;
      if (func_wr) mem_d[c][A3]       = WD3;
      if (inj_ok && (inj_copy == 2'(c)))
        mem_d[c][inj_addr][inj_bit] = ~mem_d[c][inj_addr][inj_bit];
    end
  end

  // Storage for the three copies.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < int'(NREG); r++)
          mem[c][r] <= '0;
    end else begin
      mem <= mem_d;
    end
  end

endmodule

// File: doc/tmr_register_file.md
# tmr_register_file

Triplicated, parametrised register file that replaces the single-copy register file plus single-point error-injection path of the single-cycle core. Three copies of every register are written together and read through bitwise majority voters. A background scrubber FSM walks the array and rewrites any register whose copies disagree. A programmable injection port flips one chosen bit in one chosen copy, so fault-tolerance campaigns can be run on the core.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREG, 32, number of registers (power of two, at least 4); register 0 reads as zero
- AW, $clog2(NREG), address width
- CNTW, 8, width of the corrected-error counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_in  in  1  asynchronous, active-low reset
- WE3  in  1  functional write enable
- A1, A2  in  AW  read addresses
- A3  in  AW  write address
- WD3  in  XLEN  write data
- RD1, RD2  out  XLEN  voted read data, combinational
- rd_mismatch  out  1  combinational; high when the copies at a non-zero A1 or A2 disagree in any bit
- inject_error  in  1  when high at a clock edge, apply one bit flip
- inj_copy  in  2  target copy: 0, 1 or 2; value 3 is ignored
- inj_addr  in  AW  target register
- inj_bit  in  $clog2(XLEN)  target bit
- scrub_en  in  1  enables the background scrubber
- scrub_busy  out  1  high while the FSM is in SCAN or FIX
- scrub_pass  out  1  one-cycle pulse when the scan pointer wraps from NREG-1 to 1
- corr_count  out  CNTW  number of registers corrected; saturates at all-ones

## Operation
- Voting: RDn[i] = majority of copy0[An][i], copy1[An][i] and copy2[An][i]. If An = 0, RDn = 0 and the address does not contribute to rd_mismatch.
- Functional write: when WE3 is high and A3 ≠ 0, WD3 is written to all three copies. Writes to register 0 are discarded.
- Injection: the target bit of copy[inj_copy][inj_addr] is inverted. It is ignored when inj_addr = 0 or inj_copy = 3. If a functional write hits the same register on the same edge, the stored value is WD3 with the target bit inverted in the target copy only.
- Scrubber FSM, states IDLE, SCAN and FIX:
  - IDLE: the pointer holds. Go to SCAN when scrub_en = 1.
  - SCAN: compare the three copies at ptr.
    - On mismatch: latch ptr into fix_addr and go to FIX. The pointer does not advance.
    - Otherwise advance ptr, going from NREG-1 back to 1 and pulsing scrub_pass on that wrap.
    - If scrub_en = 0, go to IDLE. This check takes precedence over the comparison.
  - FIX: write the voted value of fix_addr to all three copies, increment corr_count (saturating), advance ptr, then return to SCAN.
    - If WE3 is high with A3 ≠ 0 in the same cycle, the fix is deferred: the FSM stays in FIX and retries on the next cycle.
    - Exception: if A3 = fix_addr, the functional write repairs the register. corr_count is still incremented, ptr advances, and the FSM returns to SCAN.
  - The fix is completed even if scrub_en falls while in FIX. The FSM then goes to IDLE instead of SCAN.
- An injection on the same edge as a FIX write to the same register is applied after the fix, leaving exactly one copy faulty.

## Timing
- Reset (rst_in low, asynchronous): all copies of all registers = 0, FSM = IDLE, ptr = 1, fix_addr = 0, corr_count = 0, scrub_pass = 0, scrub_busy = 0. RD1, RD2 and rd_mismatch are then 0 by construction.
- Reads have zero latency. A write or injection at edge N is visible on RD and rd_mismatch after edge N.
- Scrub cost: 1 cycle per clean register, 2 cycles per faulty register with no conflicting write.
- A clean full pass takes NREG-1 cycles.
- Worst-case time to correct an injected fault is 2·(NREG-1) cycles plus stall cycles.
- Reset asserted mid-FIX aborts the fix and clears all state. No partial writes are retained.

## Test plan
- Reset, then write x5 = 0xDEADBEEF. Read A1 = 5 on the next cycle: RD1 = 0xDEADBEEF, rd_mismatch = 0.
- Inject copy 1, x5, bit 0. Then RD1 = 0xDEADBEEF and rd_mismatch = 1. With scrub_en = 1, within 2·(NREG-1) cycles rd_mismatch = 0 and corr_count = 1.
- Inject copy 0, x7, bit 3 and copy 2, x7, bit 3 on consecutive cycles, with x7 previously 0. RD = 0x00000008, matching the majority. After the scrub, all copies hold 0x00000008.
- Write x0 = 0xFFFFFFFF and inject into x0 → RD1 (A1 = 0) = 0, rd_mismatch = 0, corr_count unchanged.
- Fault at x9 while the FSM enters FIX, with back-to-back WE3 to x3 for 4 cycles: the FSM stays in FIX and scrub_busy = 1. The fix completes on the first cycle without a write, and corr_count increments by exactly 1.
- Force corr_count to all-ones via 2^CNTW injections and scrubs, then inject once more → the register is corrected but corr_count stays 0xFF. A clean pass pulses scrub_pass exactly once per NREG-1 cycles.
